// File: rtl/zx_cpu_clock.sv
// zx_cpu_clock: CPU/pixel clock-enable generator with ULA contention, turbo rates and stall watchdog
module zx_cpu_clock #(
  parameter int DIV_BITS  = 4,
  parameter int MAX_TURBO = 2,
  parameter int PIX_SHIFT = 3,
  parameter int MAX_STALL = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               power,
  input  logic [$clog2(MAX_TURBO+1)-1:0]     turbo,
  input  logic                               contend_en,
  input  logic                               vdu_window,
  input  logic                               mreq_n,
  input  logic                               io_ula_n,
  input  logic                               addr_contended,
  output logic                               pe_raw,
  output logic                               ne_raw,
  output logic                               pe_cpu,
  output logic                               ne_cpu,
  output logic                               pce,
  output logic                               stall,
  output logic [$clog2(MAX_TURBO+1)-1:0]     turbo_cur
);
  localparam int TW  = $clog2(MAX_TURBO + 1);
  localparam int SCW = $clog2(MAX_STALL + 1);
  localparam logic [TW-1:0] TMAX = TW'(MAX_TURBO);
  localparam logic [DIV_BITS-1:0] PMASK = {DIV_BITS{1'b1}} >> (DIV_BITS - PIX_SHIFT);
  logic [DIV_BITS-1:0] cnt, mask, phase;
  logic [SCW-1:0] stall_cnt;
  logic live, acc, access, stall_set;
  // mask selects the low S bits of cnt; its top set bit marks the rising phase
  assign live      = power & ~reset;
  assign mask      = {DIV_BITS{1'b1}} >> turbo_cur;
  assign phase     = cnt & mask;
  assign ne_raw    = live & (phase == '0);
  assign pe_raw    = live & (phase == (mask ^ (mask >> 1)));
  assign pce       = live & ((cnt & PMASK) == '0);
  assign ne_cpu    = ne_raw & ~stall;
  assign pe_cpu    = pe_raw & ~stall;
  assign access    = (~mreq_n & addr_contended) | ~io_ula_n;
  assign stall_set = contend_en && turbo_cur == '0 && vdu_window && acc && stall_cnt < SCW'(MAX_STALL);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt       <= '0;
      turbo_cur <= '0;
      acc       <= 1'b0;
      stall     <= 1'b0;
      stall_cnt <= '0;
    end else if (power) begin
      cnt <= cnt + 1'b1;
      if (&cnt) turbo_cur <= turbo > TMAX ? TMAX : turbo;
      acc <= (turbo_cur != '0 || !contend_en) ? 1'b0 : pe_cpu ? access : acc;
      if (ne_raw) begin
        stall     <= stall_set;
        stall_cnt <= stall_set ? stall_cnt + 1'b1 : '0;
      end
    end
endmodule
